mig_app_responder: RTL and testbench
====================================

Name: mig_app_responder

Overview:
Synthesizable memory-controller application-interface responder: the target side of the ui_clk command/write-data/read-data handshake that user state machines drive. It accepts app_en/app_cmd/app_addr commands and app_wdf_* write data, stores bursts in an internal RAM, and returns read bursts in order after a fixed latency. It stands in for the DDR3 controller in simulation and in on-chip loopback builds of the sound generator, so user masters can be verified without the physical memory path.

Parameters:
ADDR_W, 29, app_addr width.
DATA_W, 256, burst data width (one app_wdf_data / app_rd_data word).
MASK_W, 32, byte mask width (DATA_W/8).
DEPTH_LOG2, 6, log2 of internal RAM depth in bursts (64).
RD_LAT, 4, cycles from head-of-queue read execution to app_rd_data_valid (>=1).
CALIB_CYCLES, 16, cycles after reset before init_calib_complete rises.
CQ_DEPTH, 4, command queue depth (power of 2).
WQ_DEPTH, 4, write-data FIFO depth (power of 2).
REF_INTERVAL, 64, cycles between emulated refreshes (macro only).
REF_BUSY, 3, stall length per refresh (macro only).

Ports:
ui_clk  in  1  clock
ui_clk_sync_rst  in  1  asynchronous active-high reset
init_calib_complete  out  1  high once calibration delay elapses; stays high
app_addr  in  ADDR_W  burst address, steps of 8
app_cmd  in  3  3'b000 write, 3'b001 read, others illegal
app_en  in  1  command valid
app_rdy  out  1  command accepted when app_en && app_rdy
app_wdf_data  in  DATA_W  write burst data
app_wdf_mask  in  MASK_W  1 = byte NOT written
app_wdf_wren  in  1  write-data valid
app_wdf_end  in  1  must equal app_wdf_wren
app_wdf_rdy  out  1  write data accepted when app_wdf_wren && app_wdf_rdy
app_rd_data  out  DATA_W  read burst
app_rd_data_valid  out  1  read data strobe
app_rd_data_end  out  1  equals app_rd_data_valid
app_ref_req  in  1  user refresh request
app_ref_ack  out  1  one-cycle refresh-done pulse
app_zq_req  in  1  ZQ request
app_zq_ack  out  1  app_zq_req registered by one cycle
app_sr_active  out  1  tied 0
proto_err  out  1  sticky protocol error

Behaviour:
- Reset, asynchronous: all outputs 0, queues empty, calibration counter cleared, RAM contents not reset. Reset asserted mid-transfer discards queued commands, write data and in-flight reads; valid drops immediately.
- Calibration: counter runs from reset release; init_calib_complete rises on cycle CALIB_CYCLES and holds. app_rdy and app_wdf_rdy are 0 until it rises.
- app_rdy = calib && cmd queue not full && !ref_stall. app_wdf_rdy = calib && wdf FIFO not full && !ref_stall. Neither depends combinationally on app_en, app_cmd or app_wdf_wren.
- Accepted command pushes {cmd, addr} into the in-order queue. Write data pushes {data, mask} into the wdf FIFO independently; data may lead or trail its command.
- Queue head executes at most once per cycle, earliest the cycle after acceptance:
  - read: always executes.
  - write: executes only when the wdf FIFO is non-empty, and pops one data entry. Masked bytes keep their old value.
  - A read that follows a write to the same address returns the new data.
- RAM index = app_addr[DEPTH_LOG2+2:3]. Upper bits are ignored, so addresses wrap. app_addr[2:0] != 0 sets proto_err; the command executes with those bits ignored.
- Read pipeline: RD_LAT-stage shift register. A read executed in cycle E gives app_rd_data_valid in cycle E+RD_LAT. Minimum latency from acceptance is 1+RD_LAT. Data returns in command order. There is no back-pressure on read data.
- Illegal app_cmd: accepted, dropped at the head, sets proto_err.
- proto_err also sets on:
  - app_wdf_end != app_wdf_wren;
  - app_en while app_rdy is low and app_addr or app_cmd changed from the previous cycle.
- proto_err clears only on reset.
- Simultaneous command accept, data accept and head execution in one cycle are all legal. Occupancy counts update by net change.
- app_zq_ack is app_zq_req delayed one cycle and has no other effect.

Optional Feature:
MIG_RESP_REFRESH_EN:
- Defined: a refresh starts every REF_INTERVAL cycles after calibration, or on the next cycle after app_ref_req. ref_stall is then high for REF_BUSY cycles, forcing app_rdy and app_wdf_rdy low. Queued commands keep executing. app_ref_ack pulses on the last stall cycle. A request arriving during a stall is merged into it.
- Undefined: ref_stall is tied 0 and app_ref_ack is 0. app_ref_req is ignored.

Decomposition:
- Shared package mig_app_pkg: CMD_WRITE=3'b000, CMD_READ=3'b001, a command-entry struct {cmd, addr}, a wdf-entry struct {data, mask}, and the ADDR_W/DATA_W defaults.
- One generic sub-module, sync_fifo_pw (parameterized width and depth; full/empty flags), instantiated twice: command queue and wdf FIFO.

Test Plan:
- Reset release -> init_calib_complete rises at cycle 16. Write 20 bursts to addresses 0,8,...,152 with data 2,4,...,40, then read them back -> 20 valid beats, data 2,4,...,40 in order, first beat 5 cycles after the first read is accepted.
- Fill the queue with 4 write commands and no data -> app_rdy goes low after the 4th accept. Supply the data -> writes drain and app_rdy returns high.
- Write 0xFF..FF to address 0, then write 0 with mask 32'h0000_FFFF -> reading address 0 returns the upper 16 bytes 0 and the lower 16 bytes 0xFF.
- Write to address 0x200 (index 0 after wrap), then read address 0 -> same data. Address 0x004 -> proto_err=1.
- Assert reset while 3 reads are in flight -> app_rd_data_valid is 0 immediately and no beats appear after release.
- With MIG_RESP_REFRESH_EN: pulse app_ref_req -> app_rdy and app_wdf_rdy are low for 3 cycles and app_ref_ack pulses once; read order is preserved throughout.

Source files
------------

// File: rtl/mig_app_pkg.sv
// ---------------------------------------------------------------------------
// mig_app_pkg
// Shared types and constants for the MIG application-interface responder.
//   CMD_WRITE / CMD_READ : app_cmd encodings understood by the responder
//   cmd_entry_t          : command queue entry {cmd, addr}
//   wdf_entry_t          : write-data FIFO entry {data, mask}
//   *_DEFAULT            : default app_addr / burst data / byte mask widths;
//                          the queue entry structs are laid out at these widths
//   apply_mask()         : byte-merge of a write burst into an old RAM word
// ---------------------------------------------------------------------------
package mig_app_pkg;

    localparam int ADDR_W_DEFAULT = 29;
    localparam int DATA_W_DEFAULT = 256;
    localparam int MASK_W_DEFAULT = DATA_W_DEFAULT / 8;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef struct packed {
        logic [2:0]                cmd;
        logic [ADDR_W_DEFAULT-1:0] addr;
    } cmd_entry_t;

    typedef struct packed {
        logic [DATA_W_DEFAULT-1:0] data;
        logic [MASK_W_DEFAULT-1:0] mask;
    } wdf_entry_t;

    // A set mask bit protects the corresponding byte of the old word.
    function automatic logic [DATA_W_DEFAULT-1:0] apply_mask(
        input logic [DATA_W_DEFAULT-1:0] old_data,
        input logic [DATA_W_DEFAULT-1:0] new_data,
        input logic [MASK_W_DEFAULT-1:0] mask
    );
        logic [DATA_W_DEFAULT-1:0] merged;
        merged = old_data;
        for (int b = 0; b < MASK_W_DEFAULT; b++) begin
            if (!mask[b]) begin
                merged[b*8 +: 8] = new_data[b*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sync_fifo_pw.sv
// ---------------------------------------------------------------------------
// sync_fifo_pw
// Generic single-clock FIFO with first-word-fall-through output.
//   ui_clk, ui_clk_sync_rst : clock, asynchronous active-high reset
//   push, din               : write strobe and data (ignored while full)
//   pop                     : consume head entry (ignored while empty)
//   dout                    : current head entry, valid while !empty
//   full, empty             : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sync_fifo_pw #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             ui_clk,
    input  logic             ui_clk_sync_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    // Occupancy follows the net change so push and pop may coincide.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge ui_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/mig_app_responder.sv
// ---------------------------------------------------------------------------
// mig_app_responder
// Target side of the MIG ui_clk application interface, backed by an
// internal burst RAM, used in place of the DDR3 controller.
//   ui_clk, ui_clk_sync_rst      : clock, asynchronous active-high reset
//   init_calib_complete          : rises CALIB_CYCLES after reset release
//   app_en/app_cmd/app_addr      : command channel, handshake with app_rdy
//   app_wdf_data/mask/wren/end   : write-data channel, handshake with app_wdf_rdy
//   app_rd_data/valid/end        : in-order read return, RD_LAT after execution
//   app_ref_req/app_ref_ack      : refresh request / completion pulse
//   app_zq_req/app_zq_ack        : ZQ request, acknowledged one cycle later
//   app_sr_active                : self-refresh never entered (0)
//   proto_err                    : sticky protocol error flag
// Build option: define MIG_RESP_REFRESH_EN to emulate refresh stalls
// (periodic every REF_INTERVAL cycles or on app_ref_req, REF_BUSY long).
// ---------------------------------------------------------------------------
module mig_app_responder
    import mig_app_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEFAULT,
    parameter int DATA_W       = DATA_W_DEFAULT,
    parameter int MASK_W       = MASK_W_DEFAULT,
    parameter int DEPTH_LOG2   = 6,
    parameter int RD_LAT       = 4,
    parameter int CALIB_CYCLES = 16,
    parameter int CQ_DEPTH     = 4,
    parameter int WQ_DEPTH     = 4,
    parameter int REF_INTERVAL = 64,
    parameter int REF_BUSY     = 3
) (
    input  logic              ui_clk,
    input  logic              ui_clk_sync_rst,
    output logic              init_calib_complete,
    input  logic [ADDR_W-1:0] app_addr,
    input  logic [2:0]        app_cmd,
    input  logic              app_en,
    output logic              app_rdy,
    input  logic [DATA_W-1:0] app_wdf_data,
    input  logic [MASK_W-1:0] app_wdf_mask,
    input  logic              app_wdf_wren,
    input  logic              app_wdf_end,
    output logic              app_wdf_rdy,
    output logic [DATA_W-1:0] app_rd_data,
    output logic              app_rd_data_valid,
    output logic              app_rd_data_end,
    input  logic              app_ref_req,
    output logic              app_ref_ack,
    input  logic              app_zq_req,
    output logic              app_zq_ack,
    output logic              app_sr_active,
    output logic              proto_err
);

    localparam int CAL_W = $clog2(CALIB_CYCLES + 1);

    logic [CAL_W-1:0]      calib_cnt_q, calib_cnt_d;
    logic                  calib_q, calib_d;
    logic                  proto_err_q, proto_err_d;
    logic                  zq_ack_q, zq_ack_d;
    logic [ADDR_W-1:0]     prev_addr_q, prev_addr_d;
    logic [2:0]            prev_cmd_q, prev_cmd_d;
    logic [RD_LAT-1:0]     rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]     rd_data_q [RD_LAT];
    logic [DATA_W-1:0]     rd_data_d [RD_LAT];
    logic [DATA_W-1:0]     ram_q [2**DEPTH_LOG2];

    logic                  ref_stall;
    logic                  cq_full, cq_empty, wq_full, wq_empty;
    logic                  cq_push, cq_pop, wq_push, wq_pop;
    cmd_entry_t            cq_din, cq_head;
    wdf_entry_t            wq_din, wq_head;
    logic [DEPTH_LOG2-1:0] head_idx;
    logic                  exec_read, exec_write, drop_illegal;

    assign init_calib_complete = calib_q;
    assign app_rdy             = calib_q && !cq_full && !ref_stall;
    assign app_wdf_rdy         = calib_q && !wq_full && !ref_stall;
    assign app_rd_data         = rd_data_q[RD_LAT-1];
    assign app_rd_data_valid   = rd_valid_q[RD_LAT-1];
    assign app_rd_data_end     = rd_valid_q[RD_LAT-1];
    assign app_zq_ack          = zq_ack_q;
    assign app_sr_active       = 1'b0;
    assign proto_err           = proto_err_q;

    sync_fifo_pw #(
        .WIDTH ($bits(cmd_entry_t)),
        .DEPTH (CQ_DEPTH)
    ) u_cmd_q (
        .ui_clk          (ui_clk),
        .ui_clk_sync_rst (ui_clk_sync_rst),
        .push            (cq_push),
        .din             (cq_din),
        .pop             (cq_pop),
        .dout            (cq_head),
        .full            (cq_full),
        .empty           (cq_empty)
    );

    sync_fifo_pw #(
        .WIDTH ($bits(wdf_entry_t)),
        .DEPTH (WQ_DEPTH)
    ) u_wdf_q (
        .ui_clk          (ui_clk),
        .ui_clk_sync_rst (ui_clk_sync_rst),
        .push            (wq_push),
        .din             (wq_din),
        .pop             (wq_pop),
        .dout            (wq_head),
        .full            (wq_full),
        .empty           (wq_empty)
    );

    // Command/data acceptance and head-of-queue execution. A write at the
    // head waits for its data; reads and illegal commands never wait.
    always_comb begin
        cq_push      = app_en && app_rdy;
        cq_din.cmd   = app_cmd;
        cq_din.addr  = app_addr;
        wq_push      = app_wdf_wren && app_wdf_rdy;
        wq_din.data  = app_wdf_data;
        wq_din.mask  = app_wdf_mask;
        head_idx     = cq_head.addr[DEPTH_LOG2+2:3];
        exec_read    = !cq_empty && (cq_head.cmd == CMD_READ);
        exec_write   = !cq_empty && (cq_head.cmd == CMD_WRITE) && !wq_empty;
        drop_illegal = !cq_empty && (cq_head.cmd != CMD_READ) && (cq_head.cmd != CMD_WRITE);
        cq_pop       = exec_read || exec_write || drop_illegal;
        wq_pop       = exec_write;
    end

    // Calibration counter, protocol checks, ZQ echo and read pipeline.
    always_comb begin
        calib_cnt_d = calib_cnt_q;
        calib_d     = calib_q;
        if (!calib_q) begin
            calib_cnt_d = calib_cnt_q + CAL_W'(1);
            if (calib_cnt_q == CAL_W'(CALIB_CYCLES - 1)) begin
                calib_d = 1'b1;
            end
        end

        prev_addr_d = app_addr;
        prev_cmd_d  = app_cmd;
        zq_ack_d    = app_zq_req;

        // A stalled command must hold its address and command stable.
        proto_err_d = proto_err_q
                    || drop_illegal
                    || (app_wdf_end != app_wdf_wren)
                    || (cq_push && (app_addr[2:0] != 3'b000))
                    || (app_en && !app_rdy &&
                        ((app_addr != prev_addr_q) || (app_cmd != prev_cmd_q)));

        rd_valid_d[0] = exec_read;
        rd_data_d[0]  = exec_read ? ram_q[head_idx] : '0;
        for (int i = 1; i < RD_LAT; i++) begin
            rd_valid_d[i] = rd_valid_q[i-1];
            rd_data_d[i]  = rd_data_q[i-1];
        end
    end

    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) begin
            calib_cnt_q <= '0;
            calib_q     <= 1'b0;
            proto_err_q <= 1'b0;
            zq_ack_q    <= 1'b0;
            prev_addr_q <= '0;
            prev_cmd_q  <= '0;
            rd_valid_q  <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                rd_data_q[i] <= '0;
            end
        end else begin
            calib_cnt_q <= calib_cnt_d;
            calib_q     <= calib_d;
            proto_err_q <= proto_err_d;
            zq_ack_q    <= zq_ack_d;
            prev_addr_q <= prev_addr_d;
            prev_cmd_q  <= prev_cmd_d;
            rd_valid_q  <= rd_valid_d;
            for (int i = 0; i < RD_LAT; i++) begin
                rd_data_q[i] <= rd_data_d[i];
            end
        end
    end

    // Burst RAM keeps its contents through reset.
    always_ff @(posedge ui_clk) begin
        if (exec_write) begin
            ram_q[head_idx] <= apply_mask(ram_q[head_idx], wq_head.data, wq_head.mask);
        end
    end

`ifdef MIG_RESP_REFRESH_EN
    localparam int RT_W = $clog2(REF_INTERVAL);
    localparam int RB_W = $clog2(REF_BUSY + 1);

    logic [RT_W-1:0] ref_timer_q, ref_timer_d;
    logic [RB_W-1:0] ref_cnt_q, ref_cnt_d;
    logic            ref_due;
    logic            unused_ok;

    // A request arriving while a stall is already running is absorbed by it.
    always_comb begin
        ref_timer_d = ref_timer_q;
        ref_cnt_d   = ref_cnt_q;
        ref_due     = calib_q && ((ref_timer_q == RT_W'(REF_INTERVAL - 1)) || app_ref_req);
        if (calib_q) begin
            ref_timer_d = (ref_timer_q == RT_W'(REF_INTERVAL - 1)) ? '0 : ref_timer_q + RT_W'(1);
        end
        if (ref_cnt_q != '0) begin
            ref_cnt_d = ref_cnt_q - RB_W'(1);
        end else if (ref_due) begin
            ref_cnt_d = RB_W'(REF_BUSY);
        end
    end

    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) begin
            ref_timer_q <= '0;
            ref_cnt_q   <= '0;
        end else begin
            ref_timer_q <= ref_timer_d;
            ref_cnt_q   <= ref_cnt_d;
        end
    end

    assign ref_stall   = (ref_cnt_q != '0);
    assign app_ref_ack = (ref_cnt_q == RB_W'(1));
    assign unused_ok   = ^{cq_head.addr[ADDR_W_DEFAULT-1:DEPTH_LOG2+3], cq_head.addr[2:0]};
`else
    logic unused_ok;

    assign ref_stall   = 1'b0;
    assign app_ref_ack = 1'b0;
    assign unused_ok   = ^{cq_head.addr[ADDR_W_DEFAULT-1:DEPTH_LOG2+3], cq_head.addr[2:0],
                           app_ref_req, REF_INTERVAL[0], REF_BUSY[0]};
`endif

endmodule

// File: tb/tb_mig_app_responder.sv
module tb_mig_app_responder;

    localparam logic [2:0] WR = 3'b000;
    localparam logic [2:0] RD = 3'b001;

    logic         ui_clk = 1'b0;
    logic         ui_clk_sync_rst = 1'b1;
    logic         init_calib_complete;
    logic [28:0]  app_addr = '0;
    logic [2:0]   app_cmd = '0;
    logic         app_en = 1'b0;
    logic         app_rdy;
    logic [255:0] app_wdf_data = '0;
    logic [31:0]  app_wdf_mask = '0;
    logic         app_wdf_wren = 1'b0;
    logic         app_wdf_end = 1'b0;
    logic         app_wdf_rdy;
    logic [255:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         app_rd_data_end;
    logic         app_ref_req = 1'b0;
    logic         app_ref_ack;
    logic         app_zq_req = 1'b0;
    logic         app_zq_ack;
    logic         app_sr_active;
    logic         proto_err;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    // Reference model: burst memory plus pending write commands / data.
    logic [255:0] model_mem [64];
    bit   [63:0]  written = '0;
    int           wcmd_q [$];
    logic [255:0] wdat_q [$];
    logic [31:0]  wmask_q [$];

    typedef struct {
        logic [255:0] data;
        int           acc_cyc;
    } exp_t;
    exp_t exp_q [$];
    int   lat_q [$];

    mig_app_responder dut (
        .ui_clk              (ui_clk),
        .ui_clk_sync_rst     (ui_clk_sync_rst),
        .init_calib_complete (init_calib_complete),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .app_rd_data_end     (app_rd_data_end),
        .app_ref_req         (app_ref_req),
        .app_ref_ack         (app_ref_ack),
        .app_zq_req          (app_zq_req),
        .app_zq_ack          (app_zq_ack),
        .app_sr_active       (app_sr_active),
        .proto_err           (proto_err)
    );

    always #5 ui_clk = ~ui_clk;

    always @(posedge ui_clk) cyc++;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got hang required finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h required %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic failNow(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: got timeout required handshake (cycle %0d)", name, cyc);
    endtask

    function automatic int idx_of(input logic [28:0] a);
        return int'(a / 8) % 64;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic void apply_pending();
        int           ix;
        logic [255:0] d;
        logic [31:0]  m;
        while (wcmd_q.size() > 0 && wdat_q.size() > 0) begin
            ix = wcmd_q.pop_front();
            d  = wdat_q.pop_front();
            m  = wmask_q.pop_front();
            for (int b = 0; b < 32; b++) begin
                if (!m[b]) model_mem[ix][b*8 +: 8] = d[b*8 +: 8];
            end
            written[ix] = 1'b1;
        end
    endfunction

    // Scoreboard monitor: every read beat pops the oldest expectation.
    always @(posedge ui_clk) begin
        #1;
        if (!ui_clk_sync_rst && app_rd_data_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_beat: got beat %0h required none (cycle %0d)", app_rd_data, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("rd_data", app_rd_data, e.data);
                checkOutput("rd_end", app_rd_data_end, 1'b1);
                lat_q.push_back(cyc - e.acc_cyc);
                n_checks++;
                if (cyc - e.acc_cyc < 5) begin
                    n_fail++;
                    $display("[TB] FAIL rd_latency: got %0d required >= 5", cyc - e.acc_cyc);
                end
            end
        end
    end

    task automatic issueCmd(input logic [2:0] cmd, input logic [28:0] addr);
        int t = 0;
        @(negedge ui_clk);
        while (!app_rdy && t < 200) begin
            @(negedge ui_clk);
            t++;
        end
        if (!app_rdy) begin
            failNow("cmd_accept");
            return;
        end
        app_en   = 1'b1;
        app_cmd  = cmd;
        app_addr = addr;
        if (cmd == WR) begin
            wcmd_q.push_back(idx_of(addr));
        end else if (cmd == RD) begin
            exp_t e;
            apply_pending();
            e.data    = model_mem[idx_of(addr)];
            e.acc_cyc = cyc;
            exp_q.push_back(e);
        end
        @(posedge ui_clk);
        #1 app_en = 1'b0;
    endtask

    task automatic sendData(input logic [255:0] data, input logic [31:0] mask);
        int t = 0;
        @(negedge ui_clk);
        while (!app_wdf_rdy && t < 200) begin
            @(negedge ui_clk);
            t++;
        end
        if (!app_wdf_rdy) begin
            failNow("wdf_accept");
            return;
        end
        app_wdf_wren = 1'b1;
        app_wdf_end  = 1'b1;
        app_wdf_data = data;
        app_wdf_mask = mask;
        wdat_q.push_back(data);
        wmask_q.push_back(mask);
        apply_pending();
        @(posedge ui_clk);
        #1;
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
    endtask

    task automatic waitDrain();
        int t = 0;
        while (exp_q.size() > 0 && t < 500) begin
            @(posedge ui_clk);
            t++;
        end
        repeat (3) @(posedge ui_clk);
        checkOutput("drain_outstanding", exp_q.size(), 0);
    endtask

    task automatic waitCalib();
        int t = 0;
        while (!init_calib_complete && t < 100) begin
            @(negedge ui_clk);
            t++;
        end
        if (!init_calib_complete) failNow("calib_wait");
    endtask

    task automatic applyReset();
        ui_clk_sync_rst = 1'b1;
        app_en = 1'b0;
        app_wdf_wren = 1'b0;
        app_wdf_end = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge ui_clk);
        #1;
        checkOutput("rst_calib", init_calib_complete, 1'b0);
        checkOutput("rst_app_rdy", app_rdy, 1'b0);
        checkOutput("rst_wdf_rdy", app_wdf_rdy, 1'b0);
        checkOutput("rst_rd_valid", app_rd_data_valid, 1'b0);
        checkOutput("rst_proto_err", proto_err, 1'b0);
        checkOutput("rst_ref_ack", app_ref_ack, 1'b0);
        @(negedge ui_clk);
        ui_clk_sync_rst = 1'b0;
    endtask

    // Random mix of writes (data before or after the command) and reads of
    // already-written bursts, with random address aliasing and masks.
    task automatic applyStimulus(input int n_ops);
        for (int k = 0; k < n_ops; k++) begin
            int           ix;
            logic [28:0]  a;
            logic [255:0] d;
            logic [31:0]  m;
            ix = int'($urandom_range(0, 63));
            if (written == '0 || $urandom_range(0, 1) == 0) begin
                a = 29'(ix * 8 + int'($urandom_range(0, 7)) * 512);
                d = rand256();
                m = written[ix] ? $urandom : 32'h0;
                if ($urandom_range(0, 1) == 0) begin
                    issueCmd(WR, a);
                    sendData(d, m);
                end else begin
                    sendData(d, m);
                    issueCmd(WR, a);
                end
            end else begin
                while (!written[ix]) ix = (ix + 1) % 64;
                issueCmd(RD, 29'(ix * 8));
            end
            repeat ($urandom_range(0, 2)) @(negedge ui_clk);
        end
    endtask

    initial begin
        int t;
        int low_cnt;
        int ack_cnt;

        // Calibration delay after the first reset release.
        applyReset();
        repeat (15) @(posedge ui_clk);
        #1 checkOutput("calib_before_16", init_calib_complete, 1'b0);
        checkOutput("app_rdy_before_calib", app_rdy, 1'b0);
        @(posedge ui_clk);
        #1 checkOutput("calib_at_16", init_calib_complete, 1'b1);
        checkOutput("app_rdy_after_calib", app_rdy, 1'b1);
        checkOutput("sr_active", app_sr_active, 1'b0);

        // 20 sequential bursts written then read back in order.
        for (int i = 0; i < 20; i++) begin
            issueCmd(WR, 29'(8 * i));
            sendData(256'(2 * (i + 1)), 32'h0);
        end
        repeat (10) @(posedge ui_clk);
        lat_q.delete();
        for (int i = 0; i < 20; i++) issueCmd(RD, 29'(8 * i));
        waitDrain();
        checkOutput("seq_beats", lat_q.size(), 20);
        if (lat_q.size() > 0) checkOutput("first_read_latency", lat_q[0], 5);

        // Command queue fills when writes have no data yet.
        for (int i = 0; i < 4; i++) issueCmd(WR, 29'(8 * (40 + i)));
        checkOutput("app_rdy_queue_full", app_rdy, 1'b0);
        checkOutput("wdf_rdy_queue_full", app_wdf_rdy, 1'b1);
        for (int i = 0; i < 4; i++) sendData(rand256(), 32'h0);
        t = 0;
        while (!app_rdy && t < 20) begin
            @(negedge ui_clk);
            t++;
        end
        checkOutput("app_rdy_after_drain", app_rdy, 1'b1);
        for (int i = 0; i < 4; i++) issueCmd(RD, 29'(8 * (40 + i)));

        // Byte masking keeps the protected lower half.
        issueCmd(WR, 29'h0);
        sendData({256{1'b1}}, 32'h0);
        issueCmd(WR, 29'h0);
        sendData(256'h0, 32'h0000_FFFF);
        issueCmd(RD, 29'h0);
        waitDrain();
        checkOutput("proto_err_clean", proto_err, 1'b0);

        // Address wrap and misaligned address.
        issueCmd(WR, 29'h200);
        sendData(rand256(), 32'h0);
        issueCmd(RD, 29'h0);
        issueCmd(RD, 29'h4);
        repeat (3) @(posedge ui_clk);
        #1 checkOutput("proto_err_misaligned", proto_err, 1'b1);
        waitDrain();

        applyStimulus(40);
        waitDrain();

        // Reset while reads are in flight.
        for (int i = 0; i < 3; i++) issueCmd(RD, 29'(8 * i));
        t = 0;
        while (t < 50) begin
            @(posedge ui_clk);
            #2;
            if (app_rd_data_valid) break;
            t++;
        end
        if (t >= 50) failNow("inflight_beat");
        ui_clk_sync_rst = 1'b1;
        #1 checkOutput("valid_drops_in_reset", app_rd_data_valid, 1'b0);
        exp_q.delete();
        applyReset();
        repeat (40) @(posedge ui_clk);
        checkOutput("calib_after_rerun", init_calib_complete, 1'b1);

        // ZQ echo.
        @(negedge ui_clk);
        app_zq_req = 1'b1;
        @(posedge ui_clk);
        #1 checkOutput("zq_ack_high", app_zq_ack, 1'b1);
        @(negedge ui_clk);
        app_zq_req = 1'b0;
        @(posedge ui_clk);
        #1 checkOutput("zq_ack_low", app_zq_ack, 1'b0);

        // Illegal command is dropped and flagged.
        issueCmd(3'b010, 29'h8);
        repeat (8) @(posedge ui_clk);
        #1 checkOutput("proto_err_illegal", proto_err, 1'b1);

        // wdf_end without wren is flagged.
        applyReset();
        waitCalib();
        @(negedge ui_clk);
        app_wdf_end = 1'b1;
        @(posedge ui_clk);
        #1 checkOutput("proto_err_wdf_end", proto_err, 1'b1);
        app_wdf_end = 1'b0;

        // Refresh request behaviour.
`ifdef MIG_RESP_REFRESH_EN
        t = 0;
        while (!app_ref_ack && t < 200) begin
            @(negedge ui_clk);
            t++;
        end
        repeat (4) @(negedge ui_clk);
        app_ref_req = 1'b1;
        low_cnt = 0;
        ack_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge ui_clk);
            app_ref_req = 1'b0;
            if (!app_rdy) low_cnt++;
            if (!app_wdf_rdy) low_cnt += 100;
            if (app_ref_ack) ack_cnt++;
        end
        checkOutput("ref_stall_cycles", low_cnt, 303);
        checkOutput("ref_ack_pulses", ack_cnt, 1);
        for (int i = 0; i < 6; i++) issueCmd(RD, 29'(8 * i));
        waitDrain();
`else
        @(negedge ui_clk);
        app_ref_req = 1'b1;
        low_cnt = 0;
        ack_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge ui_clk);
            app_ref_req = 1'b0;
            if (!app_rdy || !app_wdf_rdy) low_cnt++;
            if (app_ref_ack) ack_cnt++;
        end
        checkOutput("ref_no_stall", low_cnt, 0);
        checkOutput("ref_no_ack", ack_cnt, 0);
`endif

        repeat (10) @(posedge ui_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
